// File: rtl/rally_judge.sv
// Point-decision stage ahead of the ball block: turns button presses into serve,
// return and point-award strobes, keeps both scores and latches the end of game.
module rally_judge #(
    parameter int WIN_SCORE = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_one,
    input  logic       btn_two,
    input  logic       hittable_one,
    input  logic       hittable_two,
    input  logic       start_game,
    output logic       button_one,
    output logic       button_two,
    output logic       return_one,
    output logic       return_two,
    output logic       match_one,
    output logic       match_two,
    output logic [3:0] score_one,
    output logic [3:0] score_two,
    output logic       game_over,
    output logic       winner_two
);

    // state  | meaning
    // SERVE  | waiting for a serve; presses forwarded as serve strobes
    // RALLY  | ball in play; returns, faults and misses are judged
    // DRAIN  | point awarded; wait for the ball block to drop start_game
    // OVER   | a player reached WIN_SCORE; frozen until reset
    typedef enum logic [1:0] {S_SERVE, S_RALLY, S_DRAIN, S_OVER} state_t;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_btn_one_q, r_btn_two_q;
    logic       r_hit_one_q, r_hit_two_q;
    logic       r_returned_one, r_returned_two;
    logic       r_button_one, r_button_two;
    logic       r_return_one, r_return_two;
    logic       r_match_one, r_match_two;
    logic [3:0] r_score_one, r_score_two;
    logic       r_game_over, r_winner_two;

    logic       w_press_one, w_press_two;
    logic       w_fall_one, w_fall_two;
    logic       w_lose_one, w_lose_two;
    logic       w_ret_one, w_ret_two;
    logic [3:0] w_score_one_inc, w_score_two_inc;

    logic       w_button_one, w_button_two;
    logic       w_return_one, w_return_two;
    logic       w_match_one, w_match_two;
    logic [3:0] w_score_one_nxt, w_score_two_nxt;
    logic       w_returned_one_nxt, w_returned_two_nxt;
    logic       w_game_over_nxt, w_winner_two_nxt;

    assign w_press_one = btn_one & ~r_btn_one_q;
    assign w_press_two = btn_two & ~r_btn_two_q;
    assign w_fall_one  = r_hit_one_q & ~hittable_one;
    assign w_fall_two  = r_hit_two_q & ~hittable_two;

    // A swing outside the window or letting the ball leave unreturned loses the rally.
    assign w_lose_one = (w_press_one & ~hittable_one) | (w_fall_one & ~r_returned_one);
    assign w_lose_two = (w_press_two & ~hittable_two) | (w_fall_two & ~r_returned_two);
    assign w_ret_one  = w_press_one & hittable_one & ~r_returned_one;
    assign w_ret_two  = w_press_two & hittable_two & ~r_returned_two;

    assign w_score_one_inc = r_score_one + 4'd1;
    assign w_score_two_inc = r_score_two + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_SERVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SERVE: begin
                if (start_game) w_state_nxt = S_RALLY;
            end
            S_RALLY: begin
                if (w_lose_two & ~w_lose_one)
                    w_state_nxt = (w_score_one_inc == WIN) ? S_OVER : S_DRAIN;
                else if (w_lose_one & ~w_lose_two)
                    w_state_nxt = (w_score_two_inc == WIN) ? S_OVER : S_DRAIN;
            end
            S_DRAIN: begin
                if (!start_game) w_state_nxt = S_SERVE;
            end
            default: w_state_nxt = S_OVER;
        endcase
    end

    always_comb begin
        w_button_one       = 1'b0;
        w_button_two       = 1'b0;
        w_return_one       = 1'b0;
        w_return_two       = 1'b0;
        w_match_one        = 1'b0;
        w_match_two        = 1'b0;
        w_score_one_nxt    = r_score_one;
        w_score_two_nxt    = r_score_two;
        w_returned_one_nxt = r_returned_one;
        w_returned_two_nxt = r_returned_two;
        case (r_state)
            S_SERVE: begin
                w_button_one = w_press_one;
                w_button_two = w_press_two;
                if (start_game) begin
                    w_returned_one_nxt = 1'b0;
                    w_returned_two_nxt = 1'b0;
                end
            end
            S_RALLY: begin
                w_return_one = w_ret_one;
                w_return_two = w_ret_two;
                if (w_fall_one) w_returned_one_nxt = 1'b0;
                if (w_fall_two) w_returned_two_nxt = 1'b0;
                if (w_ret_one)  w_returned_one_nxt = 1'b1;
                if (w_ret_two)  w_returned_two_nxt = 1'b1;
                // Simultaneous losses cancel out and the rally goes on.
                if (w_lose_two & ~w_lose_one) begin
                    w_match_one     = 1'b1;
                    w_score_one_nxt = w_score_one_inc;
                end else if (w_lose_one & ~w_lose_two) begin
                    w_match_two     = 1'b1;
                    w_score_two_nxt = w_score_two_inc;
                end
            end
            default: ;
        endcase
        w_game_over_nxt  = (w_state_nxt == S_OVER);
        w_winner_two_nxt = w_game_over_nxt & (w_score_two_nxt == WIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_one_q    <= 1'b0;
            r_btn_two_q    <= 1'b0;
            r_hit_one_q    <= 1'b0;
            r_hit_two_q    <= 1'b0;
            r_returned_one <= 1'b0;
            r_returned_two <= 1'b0;
            r_button_one   <= 1'b0;
            r_button_two   <= 1'b0;
            r_return_one   <= 1'b0;
            r_return_two   <= 1'b0;
            r_match_one    <= 1'b0;
            r_match_two    <= 1'b0;
            r_score_one    <= 4'd0;
            r_score_two    <= 4'd0;
            r_game_over    <= 1'b0;
            r_winner_two   <= 1'b0;
        end else begin
            r_btn_one_q    <= btn_one;
            r_btn_two_q    <= btn_two;
            r_hit_one_q    <= hittable_one;
            r_hit_two_q    <= hittable_two;
            r_returned_one <= w_returned_one_nxt;
            r_returned_two <= w_returned_two_nxt;
            r_button_one   <= w_button_one;
            r_button_two   <= w_button_two;
            r_return_one   <= w_return_one;
            r_return_two   <= w_return_two;
            r_match_one    <= w_match_one;
            r_match_two    <= w_match_two;
            r_score_one    <= w_score_one_nxt;
            r_score_two    <= w_score_two_nxt;
            r_game_over    <= w_game_over_nxt;
            r_winner_two   <= w_winner_two_nxt;
        end
    end

    assign button_one = r_button_one;
    assign button_two = r_button_two;
    assign return_one = r_return_one;
    assign return_two = r_return_two;
    assign match_one  = r_match_one;
    assign match_two  = r_match_two;
    assign score_one  = r_score_one;
    assign score_two  = r_score_two;
    assign game_over  = r_game_over;
    assign winner_two = r_winner_two;

endmodule

// File: tb/tb_rally_judge.sv
// Self-checking bench for rally_judge (WIN_SCORE=3): per-cycle expected output
// vectors are queued with the stimulus and compared against captured outputs.
module tb_rally_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_one = 1'b0, btn_two = 1'b0;
    logic       hittable_one = 1'b0, hittable_two = 1'b0, start_game = 1'b0;
    logic       button_one, button_two, return_one, return_two;
    logic       match_one, match_two, game_over, winner_two;
    logic [3:0] score_one, score_two;

    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rally_judge #(.WIN_SCORE(3)) dut (
        .clk(clk), .rst(rst),
        .btn_one(btn_one), .btn_two(btn_two),
        .hittable_one(hittable_one), .hittable_two(hittable_two),
        .start_game(start_game),
        .button_one(button_one), .button_two(button_two),
        .return_one(return_one), .return_two(return_two),
        .match_one(match_one), .match_two(match_two),
        .score_one(score_one), .score_two(score_two),
        .game_over(game_over), .winner_two(winner_two)
    );

    // {button_one,button_two,return_one,return_two,match_one,match_two,s1,s2,game_over,winner_two}
    function automatic logic [15:0] ev(input logic bo1, bo2, r1, r2, m1, m2,
                                       input logic [3:0] s1, s2, input logic go, w2);
        return {bo1, bo2, r1, r2, m1, m2, s1, s2, go, w2};
    endfunction

    function automatic logic [15:0] outs();
        return {button_one, button_two, return_one, return_two, match_one, match_two,
                score_one, score_two, game_over, winner_two};
    endfunction

    task automatic cyc(input logic b1, b2, h1, h2, sg, input logic [15:0] e);
        btn_one = b1; btn_two = b2; hittable_one = h1; hittable_two = h2; start_game = sg;
        exp_q.push_back(e);
        @(posedge clk); #1;
        act_q.push_back(outs());
    endtask

    task automatic test_reset();
        logic [15:0] e, a;
        int idx = 0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (outs() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", outs(), 16'h0000);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd0, 0,0));
        cyc(0, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd0, 0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL reset_idle[%0d]: got %h expected %h", idx, a, e); end
            idx++;
        end
    endtask

    task automatic test_serve();
        logic [15:0] e, a;
        int idx = 0;
        cyc(1, 0, 0, 0, 0, ev(1,0,0,0,0,0, 4'd0, 4'd0, 0,0));
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd0, 0,0));
        cyc(0, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd0, 0,0));
        cyc(0, 0, 0, 0, 1, ev(0,0,0,0,0,0, 4'd0, 4'd0, 0,0));
        cyc(1, 0, 0, 0, 1, ev(0,0,0,0,0,1, 4'd0, 4'd1, 0,0));
        cyc(1, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd1, 0,0));
        cyc(0, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd1, 0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL serve[%0d]: got %h expected %h", idx, a, e); end
            idx++;
        end
    endtask

    task automatic test_return();
        logic [15:0] e, a;
        int idx = 0;
        cyc(0, 0, 0, 0, 1, ev(0,0,0,0,0,0, 4'd0, 4'd1, 0,0));
        cyc(0, 0, 0, 1, 1, ev(0,0,0,0,0,0, 4'd0, 4'd1, 0,0));
        cyc(0, 1, 0, 1, 1, ev(0,0,0,1,0,0, 4'd0, 4'd1, 0,0));
        cyc(0, 0, 0, 1, 1, ev(0,0,0,0,0,0, 4'd0, 4'd1, 0,0));
        cyc(0, 1, 0, 1, 1, ev(0,0,0,0,0,0, 4'd0, 4'd1, 0,0));
        cyc(0, 0, 0, 1, 1, ev(0,0,0,0,0,0, 4'd0, 4'd1, 0,0));
        cyc(0, 0, 0, 0, 1, ev(0,0,0,0,0,0, 4'd0, 4'd1, 0,0));
        cyc(0, 0, 0, 0, 1, ev(0,0,0,0,0,0, 4'd0, 4'd1, 0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL return[%0d]: got %h expected %h", idx, a, e); end
            idx++;
        end
    endtask

    task automatic test_miss();
        logic [15:0] e, a;
        int idx = 0;
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 0, 1, ev(0,0,0,0,0,0, 4'd0, 4'd1, 0,0));
        cyc(0, 0, 0, 0, 1, ev(0,0,0,0,0,1, 4'd0, 4'd2, 0,0));
        cyc(0, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd2, 0,0));
        cyc(0, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd2, 0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL miss[%0d]: got %h expected %h", idx, a, e); end
            idx++;
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] e, a;
        int idx = 0;
        cyc(0, 0, 0, 0, 1, ev(0,0,0,0,0,0, 4'd0, 4'd2, 0,0));
        cyc(1, 1, 0, 0, 1, ev(0,0,0,0,0,0, 4'd0, 4'd2, 0,0));
        cyc(0, 0, 0, 0, 1, ev(0,0,0,0,0,0, 4'd0, 4'd2, 0,0));
        // Still in RALLY: a lone fault by player one now gives player two the game.
        cyc(1, 0, 0, 0, 1, ev(0,0,0,0,0,1, 4'd0, 4'd3, 1,1));
        cyc(0, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd3, 1,1));
        cyc(0, 1, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd3, 1,1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL simultaneous[%0d]: got %h expected %h", idx, a, e); end
            idx++;
        end
    endtask

    task automatic test_game_end();
        logic [15:0] e, a;
        int idx = 0;
        btn_one = 0; btn_two = 0; hittable_one = 0; hittable_two = 0; start_game = 0;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1, ev(0,0,0,0,0,0, 4'(i), 4'd0, 0,0));
            cyc(0, 1, 0, 0, 1, ev(0,0,0,0,1,0, 4'(i + 1), 4'd0, (i == 2), 0));
            if (i < 2) begin
                cyc(0, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'(i + 1), 4'd0, 0,0));
                cyc(0, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'(i + 1), 4'd0, 0,0));
            end
        end
        cyc(1, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd3, 4'd0, 1,0));
        cyc(0, 1, 0, 0, 0, ev(0,0,0,0,0,0, 4'd3, 4'd0, 1,0));
        cyc(1, 0, 0, 0, 1, ev(0,0,0,0,0,0, 4'd3, 4'd0, 1,0));
        btn_one = 0; btn_two = 0; start_game = 0;
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", outs(), 16'h0000);
        end
        @(negedge clk); rst = 1'b0;
        cyc(1, 0, 0, 0, 0, ev(1,0,0,0,0,0, 4'd0, 4'd0, 0,0));
        cyc(0, 0, 0, 0, 0, ev(0,0,0,0,0,0, 4'd0, 4'd0, 0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL game_end[%0d]: got %h expected %h", idx, a, e); end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_return();
        test_miss();
        test_simultaneous();
        test_game_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
